mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, clk; rst is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_read  input  1  fetch-side read request, held until i_resp.
REQ-005 i_address  input  16 (lc3b_word)  fetch-side address.
REQ-006 i_rdata  output  16  read data to fetch; always equals mem_rdata.
REQ-007 i_resp  output  1  fetch-side completion pulse.
REQ-008 d_read, d_write  input  1 each  mem-stage requests, held until d_resp.
REQ-009 d_address, d_wdata  input  16 each  mem-stage address and write data.
REQ-010 d_byte_enable  input  2 (lc3b_mem_wmask)  mem-stage write mask.
REQ-011 d_rdata  output  16  read data to the mem stage; always equals mem_rdata.
REQ-012 d_resp  output  1  mem-stage completion pulse.
REQ-013 mem_read, mem_write  output  1 each  physical memory strobes.
REQ-014 mem_address, mem_wdata  output  16 each; mem_byte_enable  output  2.
REQ-015 mem_resp  input  1; mem_rdata  input  16  physical memory response and data.

Function
REQ-016 The FSM SHALL have the states IDLE, SERVE_I and SERVE_D.
REQ-017 In IDLE, i_read alone SHALL select SERVE_I and (d_read|d_write) alone SHALL select SERVE_D, each at the next edge.
REQ-018 In IDLE with both sides requesting, the block SHALL grant the side not granted last (round-robin on last_grant).
REQ-019 last_grant SHALL reset to I, so that the first conflict after reset goes to D.
REQ-020 On the IDLE->SERVE edge, the block SHALL latch the granted side's address, wdata, byte_enable and op; mem_* SHALL be driven only from these latches.
REQ-021 In SERVE_x, mem_read or mem_write SHALL follow the latched op.
  - Grant uses d_write=1 -> write: mem_write=1, mem_read=0.
  - A fetch grant is always a read; mem_byte_enable=2'b11 for reads.
REQ-022 In IDLE, mem_read=mem_write=0; mem_address, mem_wdata and mem_byte_enable hold their last values.
REQ-023 Latency SHALL be: request sampled at edge t -> strobe high in cycle t+1 -> resp forwarded in the same cycle that mem_resp is high.
REQ-024 i_resp SHALL equal mem_resp & (state==SERVE_I), and d_resp SHALL equal mem_resp & (state==SERVE_D), combinationally.
REQ-025 mem_resp in SERVE_x SHALL return the FSM to IDLE at the next edge, giving exactly one strobe-low cycle between transactions.
REQ-026 The grant decision SHALL be made in IDLE only; a new request arriving during SERVE_x SHALL wait.
REQ-027 mem_resp seen in IDLE SHALL be ignored: no resp is forwarded and there is no state change.
REQ-028 A requester that drops its request mid-transaction SHALL NOT abort the transaction; the transaction completes, and resp is still pulsed.
REQ-029 Back-to-back requests from both sides SHALL alternate I, D, I, D...; neither side can starve.

Reset
REQ-030 With rst high at an edge, the FSM SHALL go to IDLE, last_grant to I, and latches to 0, so that mem_read=mem_write=0 and mem_address=0 the following cycle.
REQ-031 Reset mid-transaction SHALL abandon the transaction without any resp; requesters re-issue after reset.

Structure
REQ-032 The arb_state_t enum {IDLE, SERVE_I, SERVE_D} SHALL live in lc3b_types; the block SHALL reuse lc3b_word and lc3b_mem_wmask.
REQ-033 The block SHALL have a single module with no sub-module; latches and FSM are inline; the block sits between fetch/mem and the top-level memory ports.

Verification
REQ-034 Scenario: i_read=1, i_address=0x1000 alone; mem_resp after 3 cycles with rdata 0x1234. Required: mem_read=1 and mem_address=0x1000; i_resp for 1 cycle with i_rdata=0x1234; d_resp=0.
REQ-035 Scenario: d_write=1, d_address=0x2002, d_wdata=0xBEEF, d_byte_enable=2'b10. Required: mem_write=1 with the same values; mem_read=0; d_resp on mem_resp.
REQ-036 Scenario: i_read and d_read both high after reset, held continuously. Required: grants in the order D, I, D, I, with a strobe-low cycle between each.
REQ-037 Scenario: i_address changes to 0x3000 during SERVE_I. Required: mem_address stays 0x1000 until mem_resp.
REQ-038 Scenario: rst asserted during SERVE_D before mem_resp. Required: the next cycle shows IDLE, strobes=0, mem_address=0, and no d_resp.
REQ-039 Scenario: mem_resp pulsed while IDLE. Required: i_resp=d_resp=0 and the FSM stays in IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// lc3b_types : shared LC-3b word/mask types and memory-arbiter state encoding
// Revision   : 1.0
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam lc3b_mem_wmask C_FULL_WMASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin arbiter between fetch and mem-stage memory ports
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst,

    input  logic          i_read,
    input  lc3b_word      i_address,
    output lc3b_word      i_rdata,
    output logic          i_resp,

    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_word      d_address,
    input  lc3b_word      d_wdata,
    input  lc3b_mem_wmask d_byte_enable,
    output lc3b_word      d_rdata,
    output logic          d_resp,

    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_word      mem_wdata,
    output lc3b_mem_wmask mem_byte_enable,
    input  logic          mem_resp,
    input  lc3b_word      mem_rdata
);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    grant_t        r_last_grant;
    lc3b_word      r_address;
    lc3b_word      r_wdata;
    lc3b_mem_wmask r_byte_enable;
    logic          r_write;

    logic          w_i_req;
    logic          w_d_req;
    logic          w_grant_i;
    logic          w_grant_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                // On a conflict the side that did not win last time goes first
                if (w_i_req && w_d_req) begin
                    if (r_last_grant == GRANT_I) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_i = 1'b1;
                    end
                end else if (w_i_req) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i) begin
                    w_next_state = SERVE_I;
                end else if (w_grant_d) begin
                    w_next_state = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_I;
            r_address     <= '0;
            r_wdata       <= '0;
            r_byte_enable <= '0;
            r_write       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Requests are captured once so the memory side never sees requester churn
            if (w_grant_i) begin
                r_last_grant  <= GRANT_I;
                r_address     <= i_address;
                r_wdata       <= '0;
                r_byte_enable <= C_FULL_WMASK;
                r_write       <= 1'b0;
            end else if (w_grant_d) begin
                r_last_grant  <= GRANT_D;
                r_address     <= d_address;
                r_wdata       <= d_wdata;
                r_byte_enable <= d_write ? d_byte_enable : C_FULL_WMASK;
                r_write       <= d_write;
            end
        end
    end

    assign mem_read        = (r_state != IDLE) & ~r_write;
    assign mem_write       = (r_state != IDLE) &  r_write;
    assign mem_address     = r_address;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_byte_enable;

    assign i_resp  = mem_resp & (r_state == SERVE_I);
    assign d_resp  = mem_resp & (r_state == SERVE_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench with round-robin reference and memory model
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } d_txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_read = 1'b0;
    logic [15:0] i_address = '0;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_address = '0;
    logic [15:0] d_wdata = '0;
    logic [1:0]  d_byte_enable = '0;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_pass = 0;

    int mem_delay  = 3;     // negative selects a random delay 0..3
    bit spur_en    = 1'b0;
    bit spur_force = 1'b0;

    logic [15:0] i_exp_q[$];
    d_txn_t      d_exp_q[$];
    bit          side_q[$];  // 0 = fetch, 1 = mem stage

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return a ^ 16'h0234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory model: responds to a held strobe after a delay, may pulse mem_resp while idle
    initial begin : mem_model
        int cnt;
        cnt = -1;
        forever begin
            @(posedge clk);
            #2;
            mem_resp  = 1'b0;
            mem_rdata = 16'($urandom);
            if (rst || !(mem_read || mem_write)) begin
                cnt = -1;
                if (!rst && (spur_force || (spur_en && $urandom_range(0, 7) == 0)))
                    mem_resp = 1'b1;
            end else begin
                if (cnt < 0) cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
                if (cnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_data(mem_address);
                    cnt       = -1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: reference arbitration over the pending set, scoreboard pops on every resp
    initial begin : monitor
        bit prev_strobe, prev_resp_serve, prev_i_req, prev_d_req, last_d, g, strobe;
        logic [15:0] ea;
        d_txn_t de;
        prev_strobe = 0; prev_resp_serve = 0; prev_i_req = 0; prev_d_req = 0; last_d = 0;
        forever begin
            @(negedge clk);
            strobe = mem_read | mem_write;
            if (rst) begin
                side_q.delete(); i_exp_q.delete(); d_exp_q.delete();
                last_d = 0; prev_strobe = 0; prev_resp_serve = 0;
            end else begin
                if (prev_resp_serve) chk("gap_after_resp", strobe, 0);
                if (strobe && !prev_strobe) begin
                    if (prev_i_req && prev_d_req) g = ~last_d;
                    else if (prev_d_req) g = 1;
                    else if (prev_i_req) g = 0;
                    else begin fail_now("grant_without_request"); g = 0; end
                    side_q.push_back(g);
                    last_d = g;
                    chk("strobe_exclusive", mem_read & mem_write, 0);
                end
                if (mem_resp && !strobe) chk("idle_resp_ignored", {i_resp, d_resp}, 0);
                if (i_resp || d_resp) begin
                    chk("single_resp", i_resp & d_resp, 0);
                    if (side_q.size() == 0) fail_now("resp_without_grant");
                    else chk("grant_side", d_resp, side_q.pop_front());
                    if (i_resp) begin
                        if (i_exp_q.size() == 0) fail_now("i_resp_unexpected");
                        else begin
                            ea = i_exp_q.pop_front();
                            chk("i_mem_addr", mem_address, ea);
                            chk("i_mem_read", {mem_read, mem_write}, 2'b10);
                            chk("i_mem_be", mem_byte_enable, 2'b11);
                            chk("i_rdata", i_rdata, mem_data(ea));
                        end
                    end else begin
                        if (d_exp_q.size() == 0) fail_now("d_resp_unexpected");
                        else begin
                            de = d_exp_q.pop_front();
                            chk("d_mem_addr", mem_address, de.addr);
                            chk("d_mem_op", {mem_read, mem_write}, de.write ? 2'b01 : 2'b10);
                            if (de.write) begin
                                chk("d_mem_wdata", mem_wdata, de.wdata);
                                chk("d_mem_be", mem_byte_enable, de.be);
                            end else begin
                                chk("d_mem_be_rd", mem_byte_enable, 2'b11);
                                chk("d_rdata", d_rdata, mem_data(de.addr));
                            end
                        end
                    end
                end
                prev_strobe     = strobe;
                prev_resp_serve = mem_resp & strobe;
            end
            prev_i_req = i_read;
            prev_d_req = d_read | d_write;
        end
    end

    // Requester tasks are entered just after a rising edge and leave just after one
    task automatic fetch_txn(input logic [15:0] a);
        bit got;
        i_read = 1'b1;
        i_address = a;
        i_exp_q.push_back(a);
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (i_resp) got = 1;
        end
        if (!got) fail_now("i_resp_timeout");
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic d_txn(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [1:0] be);
        d_txn_t t;
        bit got;
        t.write = wr; t.addr = a; t.wdata = wd; t.be = be;
        d_read = ~wr; d_write = wr;
        d_address = a; d_wdata = wd; d_byte_enable = be;
        d_exp_q.push_back(t);
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (d_resp) got = 1;
        end
        if (!got) fail_now("d_resp_timeout");
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        @(posedge clk); #1;
        reset_dut();
        @(negedge clk);
        chk("reset_strobes", {mem_read, mem_write}, 2'b00);
        chk("reset_addr", mem_address, 16'h0000);
        chk("reset_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk); #1;

        // Lone fetch read, memory answers after 3 cycles
        mem_delay = 3;
        fetch_txn(16'h1000);
        // Lone mem-stage write with a partial mask
        d_txn(1'b1, 16'h2002, 16'hBEEF, 2'b10);

        // Both sides held from reset: D wins first, then strict alternation
        reset_dut();
        fork
            begin fetch_txn(16'h1100); fetch_txn(16'h1102); end
            begin d_txn(1'b0, 16'h2200, 16'h0, 2'b00); d_txn(1'b0, 16'h2204, 16'h0, 2'b00); end
        join

        // Fetch address changes while its transaction is in flight
        fork
            fetch_txn(16'h1000);
            begin repeat (2) begin @(posedge clk); #1; end i_address = 16'h3000; end
        join

        // Reset lands in the middle of a mem-stage transaction
        mem_delay = 6;
        d_read = 1'b1;
        d_address = 16'h4444;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_reset_serving", mem_read, 1);
        rst = 1'b1;
        d_read = 1'b0;
        @(negedge clk);
        chk("reset_mid_no_resp", d_resp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mid_strobes", {mem_read, mem_write}, 2'b00);
        chk("reset_mid_addr", mem_address, 16'h0000);
        chk("reset_mid_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk); #1;

        // Stray mem_resp while idle
        spur_force = 1'b1;
        @(posedge clk); #1;
        spur_force = 1'b0;
        @(negedge clk);
        chk("spur_idle_strobe", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        chk("spur_idle_stays", {mem_read, mem_write}, 2'b00);
        @(posedge clk); #1;

        // Randomized concurrent traffic
        mem_delay = -1;
        spur_en   = 1'b1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    fetch_txn(16'($urandom));
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    d_txn(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
                end
            end
        join
        spur_en = 1'b0;
        repeat (3) @(posedge clk);

        chk("side_q_empty", side_q.size(), 0);
        chk("i_q_empty", i_exp_q.size(), 0);
        chk("d_q_empty", d_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
